row_ingress_scheduler: RTL

- Sequences one image frame from an AXI4-Stream pixel source into the 4-row line-buffer/3x3 window datapath.
- Forwards pixels to the datapath's pixel/valid inputs.
- Throttles the source with row credits so that unread rows in the four line buffers never exceed NUM_BUFFERS.
- Returns credits on each row-complete interrupt from the datapath, and reports frame completion and protocol errors.

---
 rtl/row_ingress_scheduler.sv | 89 ++++++++
 1 files changed

// File: rtl/row_ingress_scheduler.sv
// row_ingress_scheduler: feeds one AXI4-Stream frame into the 4-row line-buffer datapath,
// throttling the source with row credits returned by the datapath's row-complete pulses.
module row_ingress_scheduler #(
    parameter int IMAGE_WIDTH  = 512,
    parameter int IW_BIT_NUM   = 9,
    parameter int IMAGE_HEIGHT = 512,
    parameter int IH_BIT_NUM   = 9,
    parameter int NUM_BUFFERS  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [7:0]            pix_out,
    output logic                  pix_out_valid,
    input  logic                  row_done_intr,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_tlast,
    output logic                  err_intr,
    output logic [IH_BIT_NUM-1:0] rows_in,
    output logic [IH_BIT_NUM-1:0] rows_out
);
    localparam int CW = $clog2(NUM_BUFFERS + 1);
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
    state_t state, state_next;
    logic [IW_BIT_NUM-1:0] col;
    logic [CW-1:0] credits;
    logic [IH_BIT_NUM-1:0] rows_out_next;
    logic accept, last_col, row_end, intr_live, cred_full, cred_inc;
    assign last_col      = col == IW_BIT_NUM'(IMAGE_WIDTH - 1);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign row_end       = accept & last_col;
    assign intr_live     = row_done_intr & (state != IDLE);
    assign cred_full     = credits == CW'(NUM_BUFFERS);
    assign cred_inc      = intr_live & ~cred_full;
    assign rows_out_next = rows_out + IH_BIT_NUM'(intr_live);
    always_ff @(posedge clk) state <= reset ? IDLE : state_next;
    // DRAIN exits on rows_out_next so the final row-complete pulse finishes the frame in its own cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = STREAM;
            STREAM: if (row_end && rows_in == IH_BIT_NUM'(IMAGE_HEIGHT - 1)) state_next = DRAIN;
            DRAIN:  if (rows_out_next >= IH_BIT_NUM'(IMAGE_HEIGHT - 2)) state_next = DONE;
            DONE:   state_next = IDLE;
        endcase
    end
    always_comb begin
        busy          = state != IDLE;
        frame_done    = state == DONE;
        s_axis_tready = (state == STREAM) && (credits != '0);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            col           <= '0;
            credits       <= CW'(NUM_BUFFERS);
            rows_in       <= '0;
            rows_out      <= '0;
            pix_out       <= '0;
            pix_out_valid <= 1'b0;
            err_tlast     <= 1'b0;
            err_intr      <= 1'b0;
        end else if (state == IDLE) begin
            pix_out_valid <= 1'b0;
            if (row_done_intr) err_intr <= 1'b1;
            if (start) begin
                col       <= '0;
                credits   <= CW'(NUM_BUFFERS);
                rows_in   <= '0;
                rows_out  <= '0;
                err_tlast <= 1'b0;
                err_intr  <= row_done_intr;
            end
        end else begin
            pix_out_valid <= accept;
            if (accept) pix_out <= s_axis_tdata;
            if (accept) col <= last_col ? '0 : col + 1'b1;
            if (row_end) rows_in <= rows_in + 1'b1;
            rows_out <= rows_out_next;
            credits  <= credits - CW'(row_end) + CW'(cred_inc);
            if (accept && (s_axis_tlast != last_col)) err_tlast <= 1'b1;
            if (row_done_intr && cred_full) err_intr <= 1'b1;
        end
    end
endmodule
